i2s_rx: RTL and testbench
=========================

// Module: i2s_rx
// PURPOSE
//  I2S slave receiver for the ADC_DOUT path. It is the capture-side counterpart of the i2s transmitter.
//  It reuses the transmitter's sclk/lrclk (I2S_BCK/I2S_LRCK), which are generated on the same clk, and deserialises
//  ADC_DOUT into stereo sample pairs. Pairs are buffered in a small show-ahead FIFO with a valid/ready handshake,
//  feeding the Sound Blaster recording (DMA write) path.
// PARAMETERS
//  AUDIO_DW    16  bits kept per channel (MSB-first; slot bits beyond AUDIO_DW ignored)
//  SLOT_BITS   32  nominal bits per channel slot (64fs); bit counter saturates here
//  FIFO_DEPTH  4   stereo pairs buffered (power of 2, >=2)
//  SYNC_IN     1   1: 2-FF synchroniser on sclk/lrclk/sdata; 0: inputs used directly
// PORTS
//  clk         in   1           system clock; must be >= 4x sclk frequency
//  reset       in   1           asynchronous, active-high reset
//  sclk        in   1           I2S bit clock (I2S_BCK)
//  lrclk       in   1           I2S word select; 0 = left, 1 = right
//  sdata       in   1           serial data from the ADC (ADC_DOUT)
//  out_l       out  AUDIO_DW    left sample at FIFO head
//  out_r       out  AUDIO_DW    right sample at FIFO head
//  out_valid   out  1           FIFO not empty
//  out_ready   in   1           consumer accepts head pair when out_valid & out_ready
//  fifo_level  out  clog2(D+1)  pairs currently stored
//  overflow    out  1           sticky: a completed pair was dropped because the FIFO was full
//  frame_err   out  1           sticky: lrclk toggled before AUDIO_DW bits were captured
//  clr_status  in   1           synchronous clear of overflow and frame_err (a same-cycle set wins)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; aligned=0; left_ok=0; bit_cnt=0. The same applies when reset is asserted mid-word.
//  Sampling:
//   - sclk, lrclk and sdata come from the same sync stage.
//   - rise = sclk_s & !sclk_d. All capture happens only on rise cycles.
//  On rise, with lr = lrclk_s and lr_prev = lrclk value at the previous rise:
//   - lr != lr_prev (slot boundary):
//     - The bit at this edge is the last bit of the old slot and is ignored.
//     - If aligned and bit_cnt < AUDIO_DW: set frame_err and clear left_ok.
//     - Then: bit_cnt <= 0; chan <= lr; aligned <= 1.
//   - lr == lr_prev and aligned and bit_cnt < AUDIO_DW:
//     - shreg <= {shreg[AUDIO_DW-2:0], sdata}; bit_cnt++.
//     - On the rise where bit_cnt becomes AUDIO_DW (word complete):
//       - chan=0: left_hold <= word; left_ok <= 1.
//       - chan=1 and left_ok: push {left_hold, word}; left_ok <= 0.
//       - chan=1 and !left_ok: word discarded.
//   - Otherwise: bit_cnt++ saturating at SLOT_BITS (no capture).
//  Alignment: data before the first lrclk transition after reset is discarded. A frame that starts with a right slot yields no pair.
//  FIFO (show-ahead):
//   - out_l/out_r = head entry, valid whenever out_valid=1.
//   - pop = out_valid & out_ready.
//   - push & !full: write the pair.
//   - push & full & !pop: drop the new pair, overflow <= 1, contents unchanged.
//   - push & full & pop: both occur; level unchanged; no overflow.
//   - push into an empty FIFO: out_valid asserts the next cycle.
//   - Read/write pointers wrap modulo FIFO_DEPTH.
//  Latency: from the clk cycle where the sync input first captures the final right-data sclk high, to out_valid=1, is
//   2*SYNC_IN+2 cycles.
//  Width: sample words are raw two's complement. No sign extension or scaling is done here.
// STRUCTURE
//  Shared package i2s_pkg:
//   - default AUDIO_DW/SLOT_BITS
//   - LR_LEFT=0 / LR_RIGHT=1 constants
//   - typedef for the stereo pair {l,r}
//  Sub-module i2s_rx_fifo:
//   - synchronous show-ahead FIFO with push/pop/full/empty/level
//   - behaviour as above; drop-on-full is handled by the parent
//  Deserialiser, edge detect and status flags stay in i2s_rx.
// TESTING
//  1. BFM: 64fs, 8 clk per sclk; left=16'h1234, right=16'hABCD; out_ready=1.
//     -> exactly one pair per frame, out_l=1234, out_r=ABCD; frame_err=0; overflow=0.
//  2. out_ready=0 for 6 frames, FIFO_DEPTH=4.
//     -> fifo_level=4, overflow=1; drain order = frames 1..4; pulse clr_status -> overflow=0.
//  3. Release reset mid right slot.
//     -> no pair from the partial frame; the first complete L/R frame after the first lrclk edge is delivered intact.
//  4. Left slot of 8 bits only.
//     -> frame_err=1; that frame produces no pair; the next normal frame (5555/AAAA) is delivered correctly.
//  5. FIFO full, out_ready=1 on the same cycle as a push.
//     -> level stays 4; overflow stays 0; head advances.
//  6. Assert reset mid-word, then run 2 frames.
//     -> outputs 0 during reset; then exactly 2 correct pairs, starting from the first transition.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default widths, channel select encoding and the stereo pair type.
package i2s_pkg;
    localparam int AUDIO_DW_DEF  = 16;
    localparam int SLOT_BITS_DEF = 32;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    typedef struct packed {
        logic [AUDIO_DW_DEF-1:0] l;
        logic [AUDIO_DW_DEF-1:0] r;
    } i2s_pair_t;
endpackage

// File: rtl/i2s_rx_if.sv
// Stereo sample stream from the I2S receiver to the recording path (valid/ready).
interface i2s_rx_if
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW = AUDIO_DW_DEF
);
    logic [AUDIO_DW-1:0] out_l;
    logic [AUDIO_DW-1:0] out_r;
    logic                out_valid;
    logic                out_ready;

    modport master (output out_l, output out_r, output out_valid, input out_ready);
    modport slave  (input out_l, input out_r, input out_valid, output out_ready);
endinterface

// File: rtl/i2s_rx_fifo.sv
// Show-ahead FIFO for stereo pairs; rdata is the head entry whenever not empty.
module i2s_rx_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sclk/lrclk/sdata on clk, deserialises stereo pairs
// and queues them for the recording path.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter  int AUDIO_DW   = AUDIO_DW_DEF,
    parameter  int SLOT_BITS  = SLOT_BITS_DEF,
    parameter  int FIFO_DEPTH = 4,
    parameter  int SYNC_IN    = 1,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sclk,
    input  logic          lrclk,
    input  logic          sdata,
    i2s_rx_if.master      rx,
    output logic [LW-1:0] fifo_level,
    output logic          overflow,
    output logic          frame_err,
    input  logic          clr_status
);
    localparam int             CW     = $clog2(SLOT_BITS + 1);
    localparam logic [CW-1:0]  DW_C   = CW'(AUDIO_DW);
    localparam logic [CW-1:0]  SLOT_C = CW'(SLOT_BITS);

    logic [2:0] raw, syn;
    logic       sclk_s, lr_s, sd_s;

    assign raw = {sclk, lrclk, sdata};

    generate
        if (SYNC_IN != 0) begin : g_sync
            logic [2:0] s1, s2;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1 <= '0;
                    s2 <= '0;
                end else begin
                    s1 <= raw;
                    s2 <= s1;
                end
            end
            assign syn = s2;
        end else begin : g_nosync
            assign syn = raw;
        end
    endgenerate

    assign {sclk_s, lr_s, sd_s} = syn;

    logic                  sclk_d, lr_prev, aligned, chan, left_ok;
    logic [CW-1:0]         bit_cnt;
    logic [AUDIO_DW-2:0]   shreg;
    logic [AUDIO_DW-1:0]   word, left_hold;
    logic [2*AUDIO_DW-1:0] pair_q, head;
    logic [1:0]            vld_pipe;
    logic                  rise, boundary, capture, word_done, short_err, pair_done;
    logic                  push, pop, full, empty, ovf_set;

    assign rise      = sclk_s & ~sclk_d;
    assign word      = {shreg, sd_s};
    assign boundary  = rise & (lr_s != lr_prev);
    assign capture   = rise & ~boundary & aligned & (bit_cnt < DW_C);
    assign word_done = capture & (bit_cnt == DW_C - 1'b1);
    assign short_err = boundary & aligned & (bit_cnt < DW_C);
    assign pair_done = word_done & (chan == LR_RIGHT) & left_ok;

    // Two-stage pipe on the completed pair keeps push latency at 2*SYNC_IN+2.
    assign push    = vld_pipe[1];
    assign pop     = rx.out_valid & rx.out_ready;
    assign ovf_set = push & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_d    <= 1'b0;
            lr_prev   <= 1'b0;
            aligned   <= 1'b0;
            chan      <= LR_LEFT;
            left_ok   <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            left_hold <= '0;
            pair_q    <= '0;
            vld_pipe  <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sclk_d   <= sclk_s;
            vld_pipe <= {vld_pipe[0], pair_done};
            if (rise) lr_prev <= lr_s;

            // The bit sampled at a slot boundary belongs to the old slot and is dropped.
            if (boundary) begin
                bit_cnt <= '0;
                chan    <= lr_s;
                aligned <= 1'b1;
                if (short_err) left_ok <= 1'b0;
            end else if (capture) begin
                shreg   <= word[AUDIO_DW-2:0];
                bit_cnt <= bit_cnt + 1'b1;
                if (word_done) begin
                    if (chan == LR_LEFT) begin
                        left_hold <= word;
                        left_ok   <= 1'b1;
                    end else begin
                        if (left_ok) pair_q <= {left_hold, word};
                        left_ok <= 1'b0;
                    end
                end
            end else if (rise && bit_cnt != SLOT_C) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (short_err)       frame_err <= 1'b1;
            else if (clr_status) frame_err <= 1'b0;

            if (ovf_set)         overflow <= 1'b1;
            else if (clr_status) overflow <= 1'b0;
        end
    end

    i2s_rx_fifo #(.WIDTH(2*AUDIO_DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pair_q),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Storage is not reset, so the head is masked while nothing is queued.
    assign rx.out_valid = ~empty;
    assign rx.out_l     = empty ? '0 : head[2*AUDIO_DW-1:AUDIO_DW];
    assign rx.out_r     = empty ? '0 : head[AUDIO_DW-1:0];
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: 64fs I2S source, 8 clk per sclk, popped pairs logged by a monitor.
module tb_i2s_rx;
    import i2s_pkg::*;

    logic       CLOCK_50   = 1'b0;
    logic       reset      = 1'b1;
    logic       sclk       = 1'b0;
    logic       lrclk      = 1'b0;
    logic       sdata      = 1'b0;
    logic       clr_status = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow, frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;
    int base;
    i2s_pair_t log_p [0:63];

    i2s_rx_if #(.AUDIO_DW(16)) rx ();

    i2s_rx #(.AUDIO_DW(16), .SLOT_BITS(32), .FIFO_DEPTH(4), .SYNC_IN(1)) dut (
        .clk        (CLOCK_50),
        .reset      (reset),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .rx         (rx),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_status (clr_status)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Inputs only change on negedges, so posedge sampling sees the pre-edge handshake.
    always @(posedge CLOCK_50) begin
        if (!reset && rx.out_valid && rx.out_ready) begin
            if (pop_cnt < 64) log_p[pop_cnt] <= {rx.out_l, rx.out_r};
            pop_cnt <= pop_cnt + 1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bitof(input logic [15:0] w, input int i);
        if (i >= 1 && i <= 16) return w[16-i];
        return 1'b0;
    endfunction

    task automatic tick(input logic lr, input logic d);
        lrclk = lr; sdata = d; sclk = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        sclk = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic slot(input logic lr, input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) tick(lr, bitof(w, i));
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r);
        slot(LR_LEFT, l, 32);
        slot(LR_RIGHT, r, 32);
    endtask

    initial begin
        rx.out_ready = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_valid", 32'(rx.out_valid), 32'h0);
        chk("rst_l", 32'(rx.out_l), 32'h0);
        chk("rst_r", 32'(rx.out_r), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        reset = 1'b0;
        @(negedge CLOCK_50);

        // basic streaming with consumer always ready
        rx.out_ready = 1'b1;
        base = pop_cnt;
        slot(LR_RIGHT, 16'h0F0F, 32);
        frame(16'h1234, 16'hABCD);
        frame(16'h1234, 16'hABCD);
        repeat (8) @(negedge CLOCK_50);
        chk("t1_pairs", 32'(pop_cnt - base), 32'd2);
        chk("t1_pair0", log_p[base], 32'h1234ABCD);
        chk("t1_pair1", log_p[base+1], 32'h1234ABCD);
        chk("t1_ferr", 32'(frame_err), 32'h0);
        chk("t1_ovf", 32'(overflow), 32'h0);

        // overflow with consumer stalled for 6 frames
        rx.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) frame(16'(16'h1000 + k), 16'(16'h2000 + k));
        repeat (8) @(negedge CLOCK_50);
        chk("t2_level", 32'(fifo_level), 32'd4);
        chk("t2_ovf", 32'(overflow), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            chk("t2_drain", {rx.out_l, rx.out_r}, {16'(16'h1000 + k), 16'(16'h2000 + k)});
            rx.out_ready = 1'b1;
            @(negedge CLOCK_50);
            rx.out_ready = 1'b0;
        end
        chk("t2_empty_lvl", 32'(fifo_level), 32'd0);
        chk("t2_empty_vld", 32'(rx.out_valid), 32'h0);
        clr_status = 1'b1;
        @(negedge CLOCK_50);
        clr_status = 1'b0;
        chk("t2_ovf_clr", 32'(overflow), 32'h0);

        // push into a full FIFO on the same cycle as a pop
        base = pop_cnt;
        for (int k = 1; k <= 4; k++) frame(16'(16'h3000 + k), 16'(16'h4000 + k));
        repeat (8) @(negedge CLOCK_50);
        chk("t5_full", 32'(fifo_level), 32'd4);
        slot(LR_LEFT, 16'h3005, 32);
        for (int i = 0; i < 16; i++) tick(LR_RIGHT, bitof(16'h4005, i));
        lrclk = LR_RIGHT; sdata = bitof(16'h4005, 16); sclk = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        sclk = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        rx.out_ready = 1'b1;
        @(negedge CLOCK_50);
        rx.out_ready = 1'b0;
        chk("t5_level", 32'(fifo_level), 32'd4);
        chk("t5_ovf", 32'(overflow), 32'h0);
        chk("t5_head", {rx.out_l, rx.out_r}, 32'h30024002);
        chk("t5_one_pop", 32'(pop_cnt - base), 32'd1);
        for (int i = 17; i < 32; i++) tick(LR_RIGHT, 1'b0);
        rx.out_ready = 1'b1;
        repeat (8) @(negedge CLOCK_50);
        chk("t5_pops", 32'(pop_cnt - base), 32'd5);
        chk("t5_last", log_p[pop_cnt-1], 32'h30054005);
        chk("t5_drained", 32'(fifo_level), 32'd0);

        // reset released in the middle of a right slot
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick(LR_RIGHT, 1'b1);
        reset = 1'b0;
        base = pop_cnt;
        for (int i = 10; i < 32; i++) tick(LR_RIGHT, 1'b1);
        frame(16'h1357, 16'h2468);
        repeat (8) @(negedge CLOCK_50);
        chk("t3_pairs", 32'(pop_cnt - base), 32'd1);
        chk("t3_pair", log_p[base], 32'h13572468);
        chk("t3_ferr", 32'(frame_err), 32'h0);

        // truncated left slot
        base = pop_cnt;
        slot(LR_LEFT, 16'h1234, 8);
        slot(LR_RIGHT, 16'hBEEF, 32);
        frame(16'h5555, 16'hAAAA);
        repeat (8) @(negedge CLOCK_50);
        chk("t4_ferr", 32'(frame_err), 32'h1);
        chk("t4_pairs", 32'(pop_cnt - base), 32'd1);
        chk("t4_pair", log_p[base], 32'h5555AAAA);
        clr_status = 1'b1;
        @(negedge CLOCK_50);
        clr_status = 1'b0;
        chk("t4_ferr_clr", 32'(frame_err), 32'h0);

        // reset asserted mid-word with a pair queued
        rx.out_ready = 1'b0;
        frame(16'h7777, 16'h8888);
        repeat (8) @(negedge CLOCK_50);
        chk("t6_queued", 32'(fifo_level), 32'd1);
        for (int i = 0; i < 10; i++) tick(LR_LEFT, bitof(16'h9999, i));
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        chk("t6_rst_valid", 32'(rx.out_valid), 32'h0);
        chk("t6_rst_l", 32'(rx.out_l), 32'h0);
        chk("t6_rst_r", 32'(rx.out_r), 32'h0);
        chk("t6_rst_level", 32'(fifo_level), 32'd0);
        for (int i = 10; i < 20; i++) tick(LR_LEFT, bitof(16'h9999, i));
        reset = 1'b0;
        for (int i = 20; i < 32; i++) tick(LR_LEFT, bitof(16'h9999, i));
        base = pop_cnt;
        rx.out_ready = 1'b1;
        slot(LR_RIGHT, 16'hCCCC, 32);
        frame(16'h0101, 16'h0202);
        frame(16'h0303, 16'h0404);
        repeat (8) @(negedge CLOCK_50);
        chk("t6_pairs", 32'(pop_cnt - base), 32'd2);
        chk("t6_pair0", log_p[base], 32'h01010202);
        chk("t6_pair1", log_p[base+1], 32'h03030404);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
